// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types, sizing helpers and parameter checks for
// the digit-serial adder.
package serial_adder_pkg;

   // Controller states
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // Legal parameter limits
   localparam int MIN_WIDTH = 1;
   localparam int MIN_DIGIT = 1;

   // Digit counter width: clog2 of the digit count, never below one bit
   function automatic int cnt_width(input int width, input int digit);
      int n;
      int w;
      n = width / digit;
      w = $clog2(n);
      if (w < 1) begin
         return 1;
      end else begin
         return w;
      end
   endfunction

   // True when WIDTH/DIGIT describe a buildable adder
   function automatic bit params_ok(input int width, input int digit);
      return (width >= MIN_WIDTH) && (digit >= MIN_DIGIT) &&
             (digit <= width) && ((width % digit) == 0);
   endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// fa_cell: one-bit combinational full adder, chained DIGIT times per cycle.
module fa_cell (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic co_o
);

   assign s_o  = a_i ^ b_i ^ c_i;
   assign co_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: adds two WIDTH-bit operands plus carry-in, DIGIT bits per
// clock, with a start/busy/done handshake. Defining SERIAL_ADDER_SUB_EN adds
// the sub_i port, which turns an accepted request into a - b.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cin_i,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub_i,
`endif
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = cnt_width(WIDTH, DIGIT);
   localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

   if (!params_ok(WIDTH, DIGIT)) begin : g_bad_params
      $error("serial_adder: WIDTH must be >= 1 and a multiple of DIGIT");
   end

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             done_q, done_d;

   logic [DIGIT:0]   chain_c;
   logic [DIGIT-1:0] chain_s;
   logic [WIDTH-1:0] res_shift;
   logic             sub_req;

`ifdef SERIAL_ADDER_SUB_EN
   assign sub_req = sub_i;
`else
   assign sub_req = 1'b0;
`endif

   // Ripple chain over the low digit of the operand registers
   assign chain_c[0] = carry_q;
   for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
      fa_cell u_fa (
         .a_i  (a_q[gi]),
         .b_i  (b_q[gi]),
         .c_i  (chain_c[gi]),
         .s_o  (chain_s[gi]),
         .co_o (chain_c[gi+1])
      );
   end

   // New digit enters at the top; after N shifts the result is aligned
   if (DIGIT == WIDTH) begin : g_res_full
      assign res_shift = chain_s;
   end else begin : g_res_shift
      assign res_shift = {chain_s, res_q[WIDTH-1:DIGIT]};
   end

   // Next-state and datapath update; done defaults low so it only pulses
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               a_d     = a_i;
               b_d     = sub_req ? ~b_i : b_i;
               carry_d = sub_req ? 1'b1 : cin_i;
               res_d   = {WIDTH{1'b0}};
               cnt_d   = {CW{1'b0}};
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            res_d   = res_shift;
            carry_d = chain_c[DIGIT];
            cnt_d   = cnt_q + CW'(1'b1);
            if (cnt_q == LAST_CNT) begin
               sum_d   = res_shift;
               cout_d  = chain_c[DIGIT];
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset abandons any operation in flight
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         a_q     <= {WIDTH{1'b0}};
         b_q     <= {WIDTH{1'b0}};
         res_q   <= {WIDTH{1'b0}};
         carry_q <= 1'b0;
         cnt_q   <= {CW{1'b0}};
         sum_q   <= {WIDTH{1'b0}};
         cout_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         done_q  <= done_d;
      end
   end

   assign busy_o = (state_q == ST_RUN);
   assign done_o = done_q;
   assign sum_o  = sum_q;
   assign cout_o = cout_q;

endmodule
